// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, state encoding and sizing helper
// for the nibble-serial adder sequencer.
package adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/nibble_adder.sv
// nibble_adder: 4-bit ripple of full adders, purely combinational.
// Ports: a, b (4b), cin -> s (4b), cout.
import adder_pkg::*;

module nibble_adder (
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds W=4*NIBBLES-bit operands one nibble per
// enabled cycle through a single nibble_adder, LSB first.
// Ports: clk, rst_n (async low), ena (global freeze), in_valid/in_ready,
// op_a/op_b/sub, out_valid/out_ready, sum, carry_out, busy.
// Option: define SUBTRACT_EN to honour sub (A + ~B + 1); otherwise
// sub is ignored and no inverter is built.
import adder_pkg::*;

module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
   input  logic                    sub,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                    carry_out,
   output logic                    busy
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = clog2(NIBBLES);

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, b_q, sum_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q, cout_q;
   logic               last;
   logic               cin_acc;

   logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
   logic                s_cout;

`ifdef SUBTRACT_EN
   logic sub_q;
   assign cin_acc = sub;
`else
   logic sub_unused;
   assign sub_unused = sub;
   assign cin_acc    = 1'b0;
`endif

   assign last = (idx_q == IDX_W'(NIBBLES - 1));

   // Slice operands: select the active nibble; B is inverted for subtract.
   always_comb begin
      a_nib = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
      b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
`ifdef SUBTRACT_EN
      if (sub_q) b_nib = ~b_nib;
`endif
   end

   nibble_adder u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry_q),
      .s    (s_nib),
      .cout (s_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else if (ena) state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef SUBTRACT_EN
         sub_q   <= 1'b0;
`endif
      end else if (ena) begin
         if (state_q == IDLE && in_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= cin_acc;
`ifdef SUBTRACT_EN
            sub_q   <= sub;
`endif
         end else if (state_q == RUN) begin
            sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= s_nib;
            carry_q <= s_cout;
            idx_q   <= idx_q + 1'b1;
            if (last) cout_q <= s_cout;
         end
      end
   end

   assign sum       = sum_q;
   assign carry_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed vectors plus a random
// back-to-back run against an A+B / A+~B+1 reference model.
module tb_nibble_serial_add_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, ena, in_valid, in_ready;
   logic [15:0] op_a, op_b, sum;
   logic        sub, out_valid, out_ready, carry_out, busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Issue one op; optionally stall ena or poke in_valid during RUN.
   task automatic xfer(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input int st_at, input int st_len,
                       input bit poke, output logic [15:0] r,
                       output logic c, output int lat);
      int g;
      @(negedge clk);
      op_a = a; op_b = b; sub = s; in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (lat == st_at && st_len > 0) ena = 1'b0;
         if (lat == st_at + st_len) ena = 1'b1;
         if (poke && lat == 1) begin
            in_valid = 1'b1;
            op_a = 16'h1111;
            op_b = 16'h2222;
            chk("run_in_ready", in_ready, 0);
         end
         if (poke && lat == 2) in_valid = 1'b0;
         @(negedge clk);
         lat++;
      end
      ena = 1'b1;
      r = sum;
      c = carry_out;
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ov_low"}, out_valid, 0);
      chk({tag, "_ir_high"}, in_ready, 1);
   endtask

   logic [15:0] r;
   logic        c;
   int          lat;
   logic [16:0] exp_q[$];
   logic [16:0] e;

   initial begin
      rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", carry_out, 0);
      rst_n = 1'b1;

      // 1: plain add
      xfer(16'h1234, 16'h4321, 1'b0, -1, 0, 1'b0, r, c, lat);
      chk("t1_sum", r, 16'h5555);
      chk("t1_cout", c, 0);
      chk("t1_lat", lat, 4);
      chk("t1_busy", busy, 1);
      drain("t1");

      // 2: full carry ripple, in_valid poked in RUN with new operands
      xfer(16'hFFFF, 16'h0001, 1'b0, -1, 0, 1'b1, r, c, lat);
      chk("t2_sum", r, 16'h0000);
      chk("t2_cout", c, 1);
      chk("t2_lat", lat, 4);
      drain("t2");
      @(negedge clk);
      chk("t2_no_accept", busy, 0);

      // 3a: backpressure
      xfer(16'hA5A5, 16'h1111, 1'b0, -1, 0, 1'b0, r, c, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_ov", out_valid, 1);
         chk("t3_hold_sum", sum, 16'hB6B6);
         chk("t3_hold_ir", in_ready, 0);
      end
      drain("t3a");

      // 3b: ena low for 3 cycles mid-RUN
      xfer(16'h9999, 16'h7777, 1'b0, 1, 3, 1'b0, r, c, lat);
      chk("t3_stall_sum", r, 16'h1110);
      chk("t3_stall_cout", c, 1);
      chk("t3_stall_lat", lat, 7);
      drain("t3b");

      // 4: reset mid-RUN after two nibbles
      @(negedge clk);
      op_a = 16'h3333; op_b = 16'h4444; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("t4_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t4_ir", in_ready, 1);
      chk("t4_ov", out_valid, 0);
      chk("t4_busy", busy, 0);
      chk("t4_sum", sum, 0);
      chk("t4_cout", carry_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(16'h0F0F, 16'h00F1, 1'b0, -1, 0, 1'b0, r, c, lat);
      chk("t4_sum_next", r, 16'h1000);
      chk("t4_cout_next", c, 0);
      drain("t4");

      // 5: subtract request
      xfer(16'h0005, 16'h0007, 1'b1, -1, 0, 1'b0, r, c, lat);
`ifdef SUBTRACT_EN
      chk("t5a_sum", r, 16'hFFFE);
      chk("t5a_cout", c, 0);
`else
      chk("t5a_sum", r, 16'h000C);
      chk("t5a_cout", c, 0);
`endif
      drain("t5a");
      xfer(16'h8000, 16'h0001, 1'b1, -1, 0, 1'b0, r, c, lat);
`ifdef SUBTRACT_EN
      chk("t5b_sum", r, 16'h7FFF);
      chk("t5b_cout", c, 1);
`else
      chk("t5b_sum", r, 16'h8001);
      chk("t5b_cout", c, 0);
`endif
      drain("t5b");

      // 6: back-to-back random with random out_ready
      begin
         int  sent, got, cyc;
         bit  pend;
         sent = 0; got = 0; cyc = 0; pend = 1'b0;
         while (got < 20 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!pend && sent < 20) begin
               op_a = 16'($urandom);
               op_b = 16'($urandom);
               sub  = 1'($urandom);
               pend = 1'b1;
            end
            in_valid  = pend;
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
`ifdef SUBTRACT_EN
               if (sub) e = {1'b0, op_a} + {1'b0, ~op_b} + 17'd1;
               else     e = {1'b0, op_a} + {1'b0, op_b};
`else
               e = {1'b0, op_a} + {1'b0, op_b};
`endif
               exp_q.push_back(e);
               sent++;
               pend = 1'b0;
            end
            if (out_valid && out_ready) begin
               chk("t6_q_nonempty", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("t6_sum", sum, e[15:0]);
                  chk("t6_cout", carry_out, e[16]);
               end
               got++;
            end
         end
         in_valid = 1'b0; out_ready = 1'b0;
         chk("t6_got", got, 20);
         chk("t6_left", exp_q.size(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
